// File: rtl/data_mem_responder.sv
// Data-memory responder: word-addressed RAM behind valid/ready request and response handshakes,
// with WAIT_CYCLES wait states. Define DMEM_ALIGN_CHECK_EN to flag misaligned accesses as errors.
module data_mem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] RangeBytes  = 32'(DEPTH) << 2;
  localparam bit          NoWait      = (WAIT_CYCLES == 0);
  localparam int unsigned WaitLoadInt = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [3:0]  WaitLoad    = WaitLoadInt[3:0];

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH];

  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [31:0]   acc_offset;
  logic [AW-1:0] acc_idx;
  logic          acc_err;
  logic          do_access;
  logic          mem_we;

  // With no wait states the access happens on the accept edge, straight from the request bus.
  always_comb begin
    acc_we     = (state_q == StIdle) ? req_we    : we_q;
    acc_addr   = (state_q == StIdle) ? req_addr  : addr_q;
    acc_wdata  = (state_q == StIdle) ? req_wdata : wdata_q;
    acc_offset = acc_addr - BASE_ADDR;
    acc_idx    = acc_offset[AW+1:2];
`ifdef DMEM_ALIGN_CHECK_EN
    acc_err    = (acc_offset >= RangeBytes) || (acc_addr[1:0] != 2'b00);
`else
    acc_err    = (acc_offset >= RangeBytes);
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    do_access   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (NoWait) begin
            do_access = 1'b1;
            state_d   = StResp;
          end else begin
            cnt_d   = WaitLoad;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          do_access = 1'b1;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          rdata_d     = 32'h0;
          err_d       = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (do_access) begin
      rsp_valid_d = 1'b1;
      err_d       = acc_err;
      rdata_d     = (!acc_we && !acc_err) ? mem_q[acc_idx] : 32'h0;
    end
  end

  assign mem_we = do_access && acc_we && !acc_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
